// File: rtl/montar_pin_pkg.sv
// montar_pin_pkg: shared PIN packet type, key codes and entry FSM states
package montar_pin_pkg;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  typedef struct packed {
    logic status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT} state_t;
  localparam pinPac_t PIN_RESET = '{status: 1'b0, digit1: DIGIT_BLANK, digit2: DIGIT_BLANK,
                                    digit3: DIGIT_BLANK, digit4: DIGIT_BLANK};
endpackage

// File: rtl/montar_pin_if.sv
// montar_pin_if: keypad strobe in, assembled PIN / status strobes out
interface montar_pin_if;
  import montar_pin_pkg::*;
  logic key_valid;
  logic [3:0] key_code;
  pinPac_t pin_out;
  logic pin_valid;
  logic [2:0] digit_count;
  logic timeout;
  modport master (output key_valid, key_code, input pin_out, pin_valid, digit_count, timeout);
  modport slave (input key_valid, key_code, output pin_out, pin_valid, digit_count, timeout);
endinterface

// File: rtl/montar_pin_inact_timer.sv
// inact_timer: counts idle ticks while enabled, flags the last tick before expiry
module inact_timer #(parameter int TIMEOUT_TICKS = 50) (
  input logic clock,
  input logic reset,
  input logic enable,
  input logic restart,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_TICKS + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // Held at zero while disabled so every new entry starts a fresh window
  assign cnt_d = (!enable || restart) ? '0 : cnt_q + 1'b1;
  assign expired = enable && cnt_q == W'(TIMEOUT_TICKS - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/montar_pin.sv
// montar_pin: assembles keypad digits into a 4-digit PIN packet with CLEAR,
// ENTER and inactivity discard
module montar_pin import montar_pin_pkg::*; #(parameter int TIMEOUT_TICKS = 50) (
  input logic clock,
  input logic reset,
  montar_pin_if.slave bus
);
  state_t state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0] count_q, count_d;
  pinPac_t pin_q, pin_d;
  logic pin_valid_q, pin_valid_d, timeout_q, timeout_d;
  logic restart, expired, dig, ent, clr;
  assign dig = bus.key_valid && bus.key_code <= 4'd9;
  assign ent = bus.key_valid && bus.key_code == KEY_ENTER;
  assign clr = bus.key_valid && bus.key_code == KEY_CLEAR;
  inact_timer #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timer (
    .clock(clock), .reset(reset), .enable(state_q == S_COLLECT),
    .restart(restart), .expired(expired)
  );
  // Key handling is shared by IDLE and COLLECT: the buffer is all blank in IDLE,
  // so shifting in the first digit lands it in digit4 with count 1
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    count_d = count_q;
    pin_d = pin_q;
    pin_valid_d = 1'b0;
    timeout_d = 1'b0;
    restart = 1'b0;
    if (state_q == S_EMIT) begin
      pin_d = pinPac_t'({count_q == 3'd4, buf_q});
      pin_valid_d = 1'b1;
      buf_d = {4{DIGIT_BLANK}};
      count_d = 3'd0;
      state_d = S_IDLE;
    end else if (dig) begin
      buf_d = {buf_q[11:0], bus.key_code};
      count_d = (count_q == 3'd4) ? count_q : count_q + 3'd1;
      restart = 1'b1;
      state_d = S_COLLECT;
    end else if (ent) begin
      state_d = S_EMIT;
    end else if (clr || expired) begin
      buf_d = {4{DIGIT_BLANK}};
      count_d = 3'd0;
      timeout_d = !clr;
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      buf_q <= {4{DIGIT_BLANK}};
      count_q <= 3'd0;
      pin_q <= PIN_RESET;
      pin_valid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      count_q <= count_d;
      pin_q <= pin_d;
      pin_valid_q <= pin_valid_d;
      timeout_q <= timeout_d;
    end
  assign bus.pin_out = pin_q;
  assign bus.pin_valid = pin_valid_q;
  assign bus.digit_count = count_q;
  assign bus.timeout = timeout_q;
endmodule

// File: doc/montar_pin.md
MONTAR_PIN -- requirements
Module: montar_pin

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 50, meaning idle ticks in COLLECT before entry is discarded (5 s at 10 Hz tick).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_valid  input  1  one-cycle strobe; key_code valid this cycle.
REQ-005 SHALL have port key_code  input  4  0x0-0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF ignored.
REQ-006 SHALL have port pin_out  output  pinPac_t (17)  last assembled PIN: status, digit1..digit4.
REQ-007 SHALL have port pin_valid  output  1  one-cycle strobe; pin_out updated this cycle.
REQ-008 SHALL have port digit_count  output  3  digits currently held, 0-4.
REQ-009 SHALL have port timeout  output  1  one-cycle strobe when an entry is discarded by inactivity.

Function
REQ-010 SHALL implement states IDLE, COLLECT, EMIT.
REQ-011 IDLE: count=0, entry buffer all 0xF; key_valid with a digit -> store as digit4, count=1, go COLLECT.
REQ-012 COLLECT, digit key: shift entry left (digit1<=digit2, digit2<=digit3, digit3<=digit4), new digit into digit4; count saturates at 4; with 4 held, oldest digit is dropped.
REQ-013 COLLECT, CLEAR key: buffer to 0xF, count=0, go IDLE; no pin_valid, no timeout.
REQ-014 ENTER in COLLECT or IDLE: go EMIT; status=1 only if count==4, else status=0 with held/unfilled (0xF) digits.
REQ-015 EMIT lasts exactly one cycle: pin_out registered from entry buffer, pin_valid=1, buffer cleared, next state IDLE.
REQ-016 Latency: ENTER strobe at cycle N -> pin_valid high at cycle N+2, pin_out stable from N+2.
REQ-017 pin_out SHALL hold its value between emissions; only EMIT changes it.
REQ-018 key_valid during EMIT SHALL be ignored.
REQ-019 Keys 0xC-0xF SHALL be ignored in every state and SHALL NOT reload the inactivity counter.
REQ-020 Inactivity counter: reloaded to 0 on every accepted key in COLLECT; increments each cycle in COLLECT; at TIMEOUT_TICKS-1 without a key -> buffer cleared, count=0, timeout=1 for one cycle, go IDLE.
REQ-021 Accepted key in the same cycle the counter expires: key wins, no timeout, counter reloaded.
REQ-022 Counter width SHALL be $clog2(TIMEOUT_TICKS+1); counter SHALL NOT run in IDLE or EMIT.
REQ-023 digit_count SHALL reflect the registered count.

Reset
REQ-024 Reset asserted at any time SHALL abort the entry and force state IDLE, count 0, counter 0.
REQ-025 Reset values: pin_out.status=0, digits 0xF; pin_valid=0; timeout=0; digit_count=0.
REQ-026 Reset SHALL dominate every simultaneous key or timeout event.

Structure
REQ-027 pinPac_t, key-code constants (KEY_CLEAR=0xA, KEY_ENTER=0xB, DIGIT_BLANK=0xF) and the state enum SHALL live in a shared package imported by this block and its consumers.
REQ-028 The inactivity counter SHALL be a sub-module inact_timer (ports: clock, reset, enable, restart, expired; parameter TIMEOUT_TICKS).
REQ-029 clock SHALL be the divided tick clock from the clock divider; no internal clock division.

Verification
REQ-030 Keys 1,2,3,4,ENTER -> pin_valid one cycle, pin_out={1,1,2,3,4}, digit_count 0 afterwards.
REQ-031 Keys 9,8,7,6,5,ENTER -> pin_out={1,8,7,6,5}; digit_count stays 4 after 5th digit.
REQ-032 Keys 1,2,ENTER -> pin_out={0,F,F,1,2}; ENTER from IDLE -> pin_out={0,F,F,F,F}.
REQ-033 Keys 3,CLEAR, then TIMEOUT_TICKS=4 with key 5 and 4 idle cycles -> timeout pulse once, no pin_valid, digit_count 0.
REQ-034 Key 7 in the expiry cycle -> no timeout, digit_count 2; key 0xD -> no state change.
REQ-035 Reset asserted mid-entry after 1,2,3 -> all outputs to reset values immediately; subsequent 4,5,6,7,ENTER -> {1,4,5,6,7}.
